// File: rtl/apb_2_axil_pkg.sv
// apb_2_axil_pkg: shared state encoding and AXI response codes for the APB to AXI4-Lite bridge
package apb_2_axil_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/apb_2_axil.sv
// apb_2_axil: APB to AXI4-Lite bridge, one outstanding transfer; APB_2_AXIL_SLVERR_EN maps SLVERR/DECERR onto pslverr_o
module apb_2_axil
  import apb_2_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    capture;
  assign capture   = (state_q == IDLE) & psel_i & penable_i;
  assign awvalid_d = (capture & pwrite_i) | (awvalid_q & ~awready_i);
  assign wvalid_d  = (capture & pwrite_i) | (wvalid_q & ~wready_i);
  assign addr_d    = capture ? paddr_i : addr_q;
  assign wdata_d   = capture ? pwdata_i : wdata_q;
  assign wstrb_d   = capture ? pstrb_i : wstrb_q;
  assign prdata_d  = (state_q == RD_DATA) & rvalid_i ? rdata_i : prdata_q;
  // AW and W retire independently; leave once neither is still pending, same-cycle included
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = capture ? (pwrite_i ? WR_ADDR_DATA : RD_ADDR) : IDLE;
      WR_ADDR_DATA: state_d = (awvalid_d | wvalid_d) ? WR_ADDR_DATA : WR_RESP;
      WR_RESP:      state_d = bvalid_i ? DONE : WR_RESP;
      RD_ADDR:      state_d = arready_i ? RD_DATA : RD_ADDR;
      RD_DATA:      state_d = rvalid_i ? DONE : RD_DATA;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prdata_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      prdata_q  <= prdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end
`ifdef APB_2_AXIL_SLVERR_EN
  logic [1:0] resp_q, resp_d;
  assign resp_d = (state_q == WR_RESP) & bvalid_i ? bresp_i :
                  (state_q == RD_DATA) & rvalid_i ? rresp_i : resp_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) resp_q <= RESP_OKAY;
    else resp_q <= resp_d;
  end
  assign pslverr_o = (state_q == DONE) & ((resp_q == RESP_SLVERR) | (resp_q == RESP_DECERR));
`else
  logic unused_resp;
  assign unused_resp = ^{bresp_i, rresp_i};
  assign pslverr_o   = 1'b0;
`endif
  assign pready_o  = state_q == DONE;
  assign prdata_o  = prdata_q;
  assign awaddr_o  = addr_q;
  assign araddr_o  = addr_q;
  assign awprot_o  = 3'b000;
  assign arprot_o  = 3'b000;
  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign bready_o  = state_q == WR_RESP;
  assign arvalid_o = state_q == RD_ADDR;
  assign rready_o  = state_q == RD_DATA;
endmodule

// File: tb/tb_apb_2_axil.sv
// tb_apb_2_axil: randomized bench for apb_2_axil against a transaction-level reference model
module tb_apb_2_axil;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o;
  logic [31:0] awaddr_o, araddr_o, wdata_o;
  logic [2:0]  awprot_o, arprot_o;
  logic [3:0]  wstrb_o;
  logic        awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  logic        awready_i, wready_i, bvalid_i, arready_i, rvalid_i;
  logic [1:0]  bresp_i, rresp_i;
  logic [31:0] rdata_i;
  always #5 clk = ~clk;
  apb_2_axil dut (
    .clk_i(clk), .rst_i(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // slave behaviour: 0 zero-wait, 1 random waits, 2 awready late after W, 3 B never returned
  int          mode = 0;
  logic [1:0]  cur_bresp = 2'b00;
  logic [1:0]  cur_rresp = 2'b00;
  logic [31:0] cur_rdata = '0;
  logic        b_fire = 1'b0;
  logic        r_fire = 1'b0;
  logic [31:0] aw_log[$];
  logic [31:0] ar_log[$];
  logic [35:0] w_log[$];
  int          b_cnt, r_cnt, w_age, held, hold_viol, prot_viol, pready_cnt;
  bit          w_done, aw_done;
  always @(negedge clk) begin
    if (pready_o) pready_cnt++;
    if (awprot_o != 3'b000 || arprot_o != 3'b000) prot_viol++;
    if (rst) begin
      bvalid_i = 1'b0;
      rvalid_i = 1'b0;
      b_fire   = 1'b0;
      r_fire   = 1'b0;
    end else begin
      if (b_fire) bvalid_i = 1'b0;
      if (r_fire) rvalid_i = 1'b0;
      if (w_done) w_age++;
      bresp_i = cur_bresp;
      rresp_i = cur_rresp;
      rdata_i = cur_rdata;
      case (mode)
        0: begin
          {awready_i, wready_i, arready_i} = 3'b111;
          bvalid_i = 1'b1;
          rvalid_i = 1'b1;
        end
        1: begin
          awready_i = 1'($urandom_range(0, 1));
          wready_i  = 1'($urandom_range(0, 1));
          arready_i = 1'($urandom_range(0, 1));
          if (!bvalid_i && $urandom_range(0, 2) == 0) bvalid_i = 1'b1;
          if (!rvalid_i && $urandom_range(0, 2) == 0) rvalid_i = 1'b1;
        end
        2: begin
          wready_i  = 1'b1;
          awready_i = w_done && w_age >= 3;
          arready_i = 1'b1;
          bvalid_i  = 1'b1;
          rvalid_i  = 1'b1;
        end
        default: begin
          {awready_i, wready_i, arready_i} = 3'b111;
          bvalid_i = 1'b0;
          rvalid_i = 1'b1;
        end
      endcase
      if (w_age >= 1 && !aw_done) begin
        held++;
        if (wvalid_o || !awvalid_o) hold_viol++;
      end
      b_fire = bvalid_i && bready_o;
      r_fire = rvalid_i && rready_o;
      if (awvalid_o && awready_i) begin
        aw_log.push_back(awaddr_o);
        aw_done = 1'b1;
      end
      if (wvalid_o && wready_i) begin
        w_log.push_back({wstrb_o, wdata_o});
        w_done = 1'b1;
      end
      if (arvalid_o && arready_i) ar_log.push_back(araddr_o);
      if (b_fire) b_cnt++;
      if (r_fire) r_cnt++;
    end
  end
  logic [31:0] model_prdata = '0;
  logic [31:0] got_prdata;
  logic        got_slverr;
  int          lat;
  task automatic clear_monitor();
    aw_log.delete();
    ar_log.delete();
    w_log.delete();
    b_cnt = 0;
    r_cnt = 0;
    w_age = 0;
    held = 0;
    hold_viol = 0;
    pready_cnt = 0;
    w_done = 1'b0;
    aw_done = 1'b0;
  endtask
  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    clear_monitor();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (pready_o) break;
    end
    check("pready_seen", pready_o, 1'b1);
    got_prdata = prdata_o;
    got_slverr = pslverr_o;
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("pready_one_cycle", pready_o, 1'b0);
  endtask
  task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] resp, input logic [31:0] rd, input int exp_lat);
    logic exp_err;
    cur_bresp = resp;
    cur_rresp = resp;
    cur_rdata = rd;
`ifdef APB_2_AXIL_SLVERR_EN
    exp_err = resp[1];
`else
    exp_err = 1'b0;
`endif
    apb_xfer(wr, a, d, s);
    if (wr) begin
      check("wr_aw_count", aw_log.size(), 1);
      check("wr_awaddr", aw_log.size() > 0 ? aw_log[0] : 32'hx, a);
      check("wr_w_count", w_log.size(), 1);
      check("wr_wdata_wstrb", w_log.size() > 0 ? w_log[0] : 36'hx, {s, d});
      check("wr_b_count", b_cnt, 1);
      check("wr_no_read", ar_log.size() + r_cnt, 0);
      check("wr_prdata_kept", got_prdata, model_prdata);
    end else begin
      model_prdata = rd;
      check("rd_ar_count", ar_log.size(), 1);
      check("rd_araddr", ar_log.size() > 0 ? ar_log[0] : 32'hx, a);
      check("rd_r_count", r_cnt, 1);
      check("rd_no_write", aw_log.size() + w_log.size() + b_cnt, 0);
      check("rd_prdata", got_prdata, model_prdata);
    end
    check("pslverr", got_slverr, exp_err);
    check("pready_count", pready_cnt, 1);
    check("prot_zero", prot_viol, 0);
    if (exp_lat > 0) check("latency", lat, exp_lat);
  endtask
  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
    bvalid_i = 1'b0; rvalid_i = 1'b0; bresp_i = '0; rresp_i = '0; rdata_i = '0;
    prot_viol = 0;
    clear_monitor();
    repeat (3) @(negedge clk);
    check("rst_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, pready_o, pslverr_o}, 7'b0);
    check("rst_prdata", prdata_o, 32'h0);
    check("rst_addr", {awaddr_o, araddr_o}, 64'h0);
    check("rst_wdata", {wstrb_o, wdata_o}, 36'h0);
    rst = 1'b0;
    mode = 0;
    run(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 3);
    run(1'b0, 32'h4, 32'h0, 4'h0, 2'b00, 32'hF00DCAFE, 3);
    mode = 2;
    run(1'b1, 32'h10, 32'h12345678, 4'h5, 2'b00, 32'h0, -1);
    check("aw_late_held_cycles", held, 3);
    check("aw_held_w_dropped", hold_viol, 0);
    mode = 0;
    run(1'b0, 32'h8, 32'h0, 4'h0, 2'b10, 32'hA5A5_5A5A, 3);
    run(1'b1, 32'hC, 32'h0BAD_F00D, 4'h3, 2'b11, 32'h0, 3);
    run(1'b0, 32'hC, 32'h0, 4'h0, 2'b01, 32'h1357_9BDF, 3);
    mode = 3;
    clear_monitor();
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h55AA_55AA; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    for (int i = 0; i < 20 && !bready_o; i++) @(negedge clk);
    check("reach_wr_resp", bready_o, 1'b1);
    rst = 1'b1;
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("abort_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, pready_o}, 6'b0);
    check("abort_prdata", prdata_o, 32'h0);
    model_prdata = '0;
    rst = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    check("abort_no_pready", pready_cnt, 0);
    run(1'b1, 32'h24, 32'hCAFE_0001, 4'h9, 2'b00, 32'h0, 3);
    mode = 1;
    repeat (40) begin
      run(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
          2'($urandom_range(0, 3)), $urandom, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_2_axil.md
APB_2_AXIL -- requirements
Module: apb_2_axil

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of APB and AXI4-Lite.
REQ-002 Parameter DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 psel_i, penable_i, pwrite_i  in  1 each  APB select, enable, direction (1 = write).
REQ-007 paddr_i  in  ADDR_WIDTH  APB address.
REQ-008 pwdata_i  in  DATA_WIDTH  write data; pstrb_i  in  DATA_WIDTH/8  byte strobes.
REQ-009 pready_o  out  1  transfer done; prdata_o  out  DATA_WIDTH  read data; pslverr_o  out  1  error.
REQ-010 awaddr_o  out  ADDR_WIDTH; awprot_o  out  3; awvalid_o  out  1; awready_i  in  1.
REQ-011 wdata_o  out  DATA_WIDTH; wstrb_o  out  DATA_WIDTH/8; wvalid_o  out  1; wready_i  in  1.
REQ-012 bresp_i  in  2; bvalid_i  in  1; bready_o  out  1.
REQ-013 araddr_o  out  ADDR_WIDTH; arprot_o  out  3; arvalid_o  out  1; arready_i  in  1.
REQ-014 rdata_i  in  DATA_WIDTH; rresp_i  in  2; rvalid_i  in  1; rready_o  out  1.

Function
REQ-015 FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-016 IDLE: on psel_i & penable_i, latch paddr_i, pwdata_i, pstrb_i into awaddr_o/araddr_o, wdata_o, wstrb_o; go to WR_ADDR_DATA if pwrite_i, else RD_ADDR.
REQ-017 awvalid_o and wvalid_o rise together in the cycle after the access phase is captured; each falls independently on its own valid&ready edge.
REQ-018 WR_ADDR_DATA -> WR_RESP once both AW and W have handshaked, including the same-cycle case.
REQ-019 bready_o high only in WR_RESP; on bvalid_i & bready_o capture bresp_i; go to DONE.
REQ-020 arvalid_o high in RD_ADDR until arvalid_o & arready_i; then RD_DATA.
REQ-021 rready_o high only in RD_DATA; on rvalid_i & rready_o capture rdata_i into prdata_o and rresp_i; go to DONE.
REQ-022 Ready or valid signals asserted early by the AXI slave (before the bridge's valid/ready) are legal; a handshake completes only when both are high at a clock edge.
REQ-023 DONE: pready_o = 1 for exactly one cycle; then IDLE unconditionally.
REQ-024 Latency: access phase captured at edge N; pready_o high no earlier than cycle N+3 (write) or N+3 (read) with zero-wait slaves.
REQ-025 prdata_o holds the last read data until the next read completes; writes leave it unchanged.
REQ-026 awprot_o = arprot_o = 3'b000 always.
REQ-027 psel_i/penable_i are ignored outside IDLE; one outstanding transfer only.

Reset
REQ-028 While rst_i is high at an edge: state = IDLE; all valid/ready/pready/pslverr outputs 0; prdata_o, addresses, wdata_o, wstrb_o 0.
REQ-029 Reset mid-transfer aborts it and drops all valids the next cycle; no pready_o is generated for the aborted transfer.

Configuration
REQ-030 Macro APB_2_AXIL_SLVERR_EN defined: pslverr_o = captured resp[1] (SLVERR/DECERR), valid only while pready_o is high, else 0.
REQ-031 Macro APB_2_AXIL_SLVERR_EN undefined: pslverr_o is tied to 0; the response code is ignored.

Structure
REQ-032 Package apb_2_axil_pkg holds the FSM state enum and the AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 Write: paddr 0x4, pwdata 0xDEADBEEF, pstrb 0xF, awready/wready/bvalid pre-asserted, bresp 0 -> awaddr 0x4, wdata 0xDEADBEEF, wstrb 0xF, one-cycle pready_o, pslverr_o 0.
REQ-035 Read: paddr 0x4, arready and rvalid pre-asserted, rdata 0xF00DCAFE -> araddr 0x4, prdata_o 0xF00DCAFE with pready_o, pslverr_o 0.
REQ-036 Write with awready delayed 3 cycles after wready -> AW held valid, W dropped after its handshake, a single B handshake, pready_o once.
REQ-037 Read with rresp 2'b10 -> pslverr_o 1 with pready_o (macro defined) or 0 (undefined).
REQ-038 rst_i asserted during WR_RESP -> all valids 0 next cycle, no pready_o, next write completes normally.
